// File: rtl/mac_pkg.sv
// Shared MAC configuration: default widths and the width formulas used by
// the bit adder and by the shift accumulator.
package mac_pkg;

   // Default configuration of the parallel-MAC datapath
   localparam int M_DEF  = 16;  // lanes summed by the adder
   localparam int PA_DEF = 8;   // activation width
   localparam int PW_DEF = 4;   // weight-slice width / shift per slice
   localparam int N_DEF  = 2;   // slices per result

   // Width of one adder partial sum: Pa*Pw product grown by log2(M) lanes
   function automatic int sum_width(input int m, input int pa, input int pw);
      return pa + pw + $clog2(m);
   endfunction

   // Accumulator width: partial sum shifted by Pw for every later slice,
   // plus one guard bit so the full shift-and-add never overflows
   function automatic int acc_width(input int sw, input int pw, input int n);
      return sw + pw * (n - 1) + 1;
   endfunction

   // Slice counter width; a single-slice build still needs one bit
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/skid_out_reg.sv
// Output result register with valid/ready handshake. Holds its data while
// valid && !ready; a new load may coincide with a downstream accept so
// results stream with no bubble. Shared by the MAC result stages.
module skid_out_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   output logic [W-1:0] data,
   output logic         valid,
   input  logic         ready,
   output logic         stall
);

   // Upstream must not load while a result is waiting on a busy consumer
   assign stall = valid && !ready;

   // Result register: load wins over drain, drain clears valid, otherwise hold
   always_ff @(posedge clk) begin
      if (rst) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= load_data;
         valid <= 1'b1;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/shift_accumulator.sv
// Shift-and-add combiner for the parallel-MAC adder output. Receives N
// partial sums MSB slice first and emits one AW-bit dot-product result.
// Build option: SIGNED_MSB_EN gives the MSB slice two's-complement weight.
module shift_accumulator
   import mac_pkg::*;
#(
   parameter  int M  = M_DEF,
   parameter  int Pa = PA_DEF,
   parameter  int Pw = PW_DEF,
   parameter  int N  = N_DEF,
   localparam int SW = sum_width(M, Pa, Pw),
   localparam int AW = acc_width(SW, Pw, N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [SW-1:0] in_sum,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [AW-1:0] out_result,
   output logic          out_valid,
   input  logic          out_ready
);

   localparam int CW = cnt_width(N);

   logic [AW-1:0] acc;
   logic [AW-1:0] acc_next;
   logic [AW-1:0] sum_ext;
   logic [CW-1:0] cnt;
   logic          first;
   logic          last;
   logic          accept;
   logic          stall;

   assign sum_ext = AW'(in_sum);
   assign first   = (cnt == '0);
   assign last    = (cnt == CW'(N - 1));

   // Intermediate slices always go in; only the closing slice can collide
   // with a result still waiting downstream. Flush drops the beat.
   assign in_ready = !flush && !(last && stall);
   assign accept   = in_valid && in_ready;

   // Next accumulator value: the MSB slice seeds acc, later slices shift-add
   always_comb begin
      acc_next = (acc << Pw) + sum_ext;
      if (first) begin
`ifdef SIGNED_MSB_EN
         acc_next = '0 - sum_ext;
`else
         acc_next = sum_ext;
`endif
      end
   end

   // Slice counter and partial accumulator; flush abandons the partial result
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         cnt <= '0;
      end else if (flush) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         acc <= acc_next;
         cnt <= last ? '0 : cnt + CW'(1);
      end
   end

   // The final shift-add feeds the output register directly, so the result
   // appears one cycle after the last slice is taken
   skid_out_reg #(
      .W (AW)
   ) u_out (
      .clk       (clk),
      .rst       (rst),
      .load      (accept && last),
      .load_data (acc_next),
      .data      (out_result),
      .valid     (out_valid),
      .ready     (out_ready),
      .stall     (stall)
   );

endmodule

// File: tb/tb_shift_accumulator.sv
// Bench for shift_accumulator: directed spec cases plus randomized traffic
// checked against a transaction-level model (slice list -> weighted sum).
module tb_shift_accumulator;

   localparam int M  = 16;
   localparam int Pa = 8;
   localparam int Pw = 4;
   localparam int N  = 2;
   localparam int SW = Pa + Pw + $clog2(M);
   localparam int AW = SW + Pw * (N - 1) + 1;
`ifdef SIGNED_MSB_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [SW-1:0] in_sum;
   logic [AW-1:0] out_result;

   int total = 0;
   int bad   = 0;

   // model state
   int unsigned   slices[$];
   bit            has_pend;
   logic [AW-1:0] pend_val;

   // last sampled / predicted values
   logic          obs_in_ready, obs_out_valid, exp_in_ready, exp_out_valid;
   logic [AW-1:0] obs_out_result, exp_out_result;

   shift_accumulator #(.M(M), .Pa(Pa), .Pw(Pw), .N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_sum     (in_sum),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_result (out_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   // Dot product from the slice list: slice i weighs 2^(Pw*(N-1-i)),
   // MSB slice negative in the signed build; wrapped to AW bits
   function automatic logic [AW-1:0] ref_result();
      longint r = 0;
      longint term;
      for (int i = 0; i < N; i++) begin
         term = longint'(slices[i]) * (longint'(1) << (Pw * (N - 1 - i)));
         if (SGN && i == 0) r = r - term;
         else               r = r + term;
      end
      return r[AW-1:0];
   endfunction

   // One clock: drive, sample/predict at negedge, advance model at posedge
   task automatic cycle(input logic v, input logic [SW-1:0] d, input logic fl,
                        input logic ordy, input logic r);
      bit in_x, out_x;
      in_valid = v; in_sum = d; flush = fl; out_ready = ordy; rst = r;
      @(negedge clk);
      obs_in_ready   = in_ready;
      obs_out_valid  = out_valid;
      obs_out_result = out_result;
      exp_in_ready   = !fl && !(slices.size() == N - 1 && has_pend && !ordy);
      exp_out_valid  = has_pend;
      exp_out_result = pend_val;
      @(posedge clk);
      if (r) begin
         slices.delete();
         has_pend = 1'b0;
         pend_val = '0;
      end else begin
         in_x  = v && exp_in_ready;
         out_x = has_pend && ordy;
         if (out_x) has_pend = 1'b0;
         if (fl) slices.delete();
         else if (in_x) begin
            slices.push_back(int'(d));
            if (slices.size() == N) begin
               pend_val = ref_result();
               has_pend = 1'b1;
               slices.delete();
            end
         end
      end
      #1;
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, '0, 1'b0, ordy, 1'b0);
   endtask

   task automatic test_reset();
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      idle(1'b0);
      total++;
      if (obs_out_valid !== 1'b0 || obs_out_result !== '0 || obs_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset: valid=%b result=%h in_ready=%b, want 0/0/1",
                  obs_out_valid, obs_out_result, obs_in_ready);
      end
   endtask

   task automatic test_basic();
      logic [AW-1:0] want = SGN ? 21'h1FFFD5 : 21'h00035;
      cycle(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 16'h0005, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      total++;
      if (obs_out_valid !== 1'b1 || obs_out_result !== want) begin
         bad++;
         $display("FAIL basic: valid=%b result=%h, want 1/%h", obs_out_valid, obs_out_result, want);
      end
      idle(1'b1);
      total++;
      if (obs_out_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_one_cycle: valid=%b, want 0", obs_out_valid);
      end
   endtask

   task automatic test_max();
      logic [AW-1:0] want = SGN ? 21'h11000F : 21'h10FFEF;
      cycle(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      total++;
      if (obs_out_valid !== 1'b1 || obs_out_result !== want) begin
         bad++;
         $display("FAIL max: valid=%b result=%h, want 1/%h", obs_out_valid, obs_out_result, want);
      end
      cycle(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      total++;
      if (obs_out_result !== 21'h00FFFF) begin
         bad++;
         $display("FAIL zero_msb: result=%h, want 00ffff", obs_out_result);
      end
   endtask

   task automatic test_backpressure();
      logic [AW-1:0] want1 = SGN ? 21'h1FFFD5 : 21'h00035;
      logic [AW-1:0] want2 = SGN ? 21'h1FFFF2 : 21'h00012;
      cycle(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
      total++;
      if (obs_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_mid_slice: in_ready=%b, want 1", obs_in_ready);
      end
      cycle(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
      total++;
      if (obs_in_ready !== 1'b0 || obs_out_valid !== 1'b1 || obs_out_result !== want1) begin
         bad++;
         $display("FAIL bp_stall: in_ready=%b valid=%b result=%h, want 0/1/%h",
                  obs_in_ready, obs_out_valid, obs_out_result, want1);
      end
      cycle(1'b1, 16'h0002, 1'b0, 1'b1, 1'b0);
      total++;
      if (obs_in_ready !== 1'b1 || obs_out_result !== want1) begin
         bad++;
         $display("FAIL bp_release: in_ready=%b result=%h, want 1/%h", obs_in_ready, obs_out_result, want1);
      end
      idle(1'b1);
      total++;
      if (obs_out_valid !== 1'b1 || obs_out_result !== want2) begin
         bad++;
         $display("FAIL bp_no_gap: valid=%b result=%h, want 1/%h", obs_out_valid, obs_out_result, want2);
      end
      idle(1'b1);
   endtask

   task automatic test_flush();
      logic [AW-1:0] want = SGN ? 21'h1FFFE3 : 21'h00023;
      cycle(1'b1, 16'h0007, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 16'h0009, 1'b1, 1'b1, 1'b0);
      total++;
      if (obs_in_ready !== 1'b0) begin
         bad++;
         $display("FAIL flush_ready: in_ready=%b, want 0", obs_in_ready);
      end
      cycle(1'b1, 16'h0002, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      total++;
      if (obs_out_valid !== 1'b1 || obs_out_result !== want) begin
         bad++;
         $display("FAIL flush: valid=%b result=%h, want 1/%h", obs_out_valid, obs_out_result, want);
      end
      idle(1'b1);
   endtask

   task automatic test_reset_mid();
      logic [AW-1:0] want = SGN ? 21'h1FFFF1 : 21'h00011;
      cycle(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      idle(1'b1);
      total++;
      if (obs_out_valid !== 1'b0 || obs_out_result !== '0 || obs_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid: valid=%b result=%h in_ready=%b, want 0/0/1",
                  obs_out_valid, obs_out_result, obs_in_ready);
      end
      cycle(1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
      idle(1'b1);
      total++;
      if (obs_out_valid !== 1'b1 || obs_out_result !== want) begin
         bad++;
         $display("FAIL reset_mid_after: valid=%b result=%h, want 1/%h", obs_out_valid, obs_out_result, want);
      end
      idle(1'b1);
   endtask

   task automatic test_random();
      logic [SW-1:0] d;
      int            errs = 0;
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 7))
            0:       d = '1;
            1:       d = '0;
            default: d = SW'($urandom);
         endcase
         cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 15) == 0,
               $urandom_range(0, 9) < 7, $urandom_range(0, 79) == 0);
         total++;
         if (obs_in_ready !== exp_in_ready || obs_out_valid !== exp_out_valid ||
             obs_out_result !== exp_out_result) begin
            bad++;
            if (errs < 10)
               $display("FAIL random[%0d]: in_ready=%b valid=%b result=%h, want %b/%b/%h", i,
                        obs_in_ready, obs_out_valid, obs_out_result,
                        exp_in_ready, exp_out_valid, exp_out_result);
            errs++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
      has_pend = 1'b0; pend_val = '0;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_max();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
